fcp_credit_gate: RTL and testbench
==================================

# fcp_credit_gate

- Sender-side admission stage that sits directly upstream of the pipelined downstream switch model.
- Accepts single-cell packets, parses the VC from `tdata`, and forwards each packet to the switch only when it has both per-VC credit and global buffer credit.
- Credit state comes from the switch's FCP stream (`fcp_fccr` per VC, `fcp_fccl` global) and from the block's own transmitted-cell counters.
- Blocking head-of-line gate: one holding register, no reordering.

## Interface
Parameters:
- QUEUE_INDEX_WIDTH, 13, VC index width (2^13 VCs)
- DATA_WIDTH, 64, packet cell width
- STAT_WIDTH, 32, counter width for all credit arithmetic
- VC_FIELD_LSB, 16, bit offset of the VC field in tdata
- VC_WINDOW, 16, max outstanding cells per VC
- INIT_FCCL, 4096, global credit limit after reset (equals switch BUFFER_DEPTH)

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_pkt_tdata  in  DATA_WIDTH  ingress cell
- s_axis_pkt_tvalid  in  1  ingress valid
- s_axis_pkt_tlast  in  1  passed through; always 1 (single-cell packets)
- s_axis_pkt_tready  out  1  ingress ready
- m_axis_pkt_tdata  out  DATA_WIDTH  cell to switch
- m_axis_pkt_tvalid  out  1  egress valid
- m_axis_pkt_tlast  out  1  egress last
- m_axis_pkt_tready  in  1  switch ready
- fcp_valid  in  1  FCP update strobe
- fcp_vc  in  QUEUE_INDEX_WIDTH  VC of the update
- fcp_fccr  in  STAT_WIDTH  cumulative cells drained on fcp_vc
- fcp_fccl  in  STAT_WIDTH  global credit limit snapshot
- init_done  out  1  table clear complete
- stall_vc_cnt  out  STAT_WIDTH  cycles the head cell was blocked by VC credit
- stall_glb_cnt  out  STAT_WIDTH  cycles the head cell was blocked by global credit only

## Operation
- **State.** Per-VC tables `tx_cnt[vc]` and `fccr[vc]` (distributed RAM, async read). Global registers `glb_tx` and `glb_fccl`.
- **FSM, INIT state.** Entered on rst. Walks addr 0..2^QIW-1, writing 0 to both tables, one entry per cycle. During INIT: `s_axis_pkt_tready` = 0, FCP is ignored, `init_done` = 0.
- **FSM, INIT→RUN.** Taken in the cycle after addr 2^QIW-1 is written. On entry, `init_done` = 1.
- **Holding register H.** Fields: `h_valid`, `h_data`, `h_vc` (`tdata[VC_FIELD_LSB +: QIW]`), `h_last`.
- **vc_ok.** (tx_cnt[h_vc] − fccr_eff) mod 2^STAT_WIDTH < VC_WINDOW.
  - fccr_eff = `fcp_fccr` if an accepted FCP update targets `h_vc` this cycle (bypass); otherwise `fccr[h_vc]`.
- **glb_ok.** $signed(glb_fccl_eff − glb_tx) > 0.
  - glb_fccl_eff = `fcp_fccl` when `fcp_valid`; otherwise `glb_fccl`.
- **fire.** fire = h_valid & vc_ok & glb_ok & (!m_valid | m_tready).
  - On fire: load the output register from H, `tx_cnt[h_vc]`++, `glb_tx`++.
- **s_axis_pkt_tready.** = RUN & (!h_valid | fire). Back-to-back cells on the same VC see the updated tx_cnt, because the write lands at the edge before the next read.
- **FCP accept.**
  - `fccr[fcp_vc]` is written only if $signed(fcp_fccr − fccr[fcp_vc]) > 0. Stale or duplicate updates are dropped.
  - `glb_fccl` is written on every `fcp_valid`.
- **Stall counters.**
  - When h_valid & !vc_ok: `stall_vc_cnt`++.
  - Else when h_valid & !glb_ok: `stall_glb_cnt`++.
  - Both counters saturate at all-ones.

## Timing
- **Reset values.** `m_axis_pkt_tvalid` 0, `m_axis_pkt_tdata` 0, `m_axis_pkt_tlast` 0, `s_axis_pkt_tready` 0, `init_done` 0, stall counters 0, `glb_tx` 0, `glb_fccl` INIT_FCCL, h_valid 0.
- **Reset duration.** `init_done` rises 2^QIW+1 cycles after rst deasserts.
- **Latency.** A cell accepted at edge k appears on m_axis after edge k+1 at the earliest (2 cycles).
- **Throughput.** 1 cell/cycle while credit and `m_axis_pkt_tready` hold.
- **AXI-S rule.** m_axis data/valid are stable while valid & !ready.
- **FCP bypass.** An FCP update for `h_vc` in the same cycle unblocks H that cycle.
- **Wrap-around.** All counters are modular STAT_WIDTH. The vc_ok/glb_ok/stale checks must stay correct across 2^32 wrap.
- **Simultaneous fire and FCP on the same VC.** These touch different tables, so there is no conflict.
- **Reset mid-operation.** H and the output register are discarded and INIT restarts. In-flight cells are lost; the switch must be reset in step.

## Structure
- Package `fcp_pkg`: stat_t (STAT_WIDTH), vc_t (QIW), the VC_FIELD_LSB constant, and the modular `credit_lt` / `newer` comparison functions.
- Sub-module `vc_credit_table`:
  - per-VC tx_cnt/fccr RAMs
  - INIT walker
  - stale-filtered FCP write
  - async read with FCP bypass
- The top level holds H, the output register, the global credit registers and the stall counters.

## Test plan
- **Reset.** rst 1 cycle → tready=0 for 8193 cycles, then init_done=1; all reads return tx_cnt=0 and fccr=0.
- **VC window.** 20 cells on VC 5, no FCP, m_tready=1 → exactly 16 forwarded, then tready=0 and stall_vc_cnt increments every cycle. FCP(vc5, fccr=4) → 4 more pass.
- **Global credit.** FCP fccl=10, cells spread over 12 VCs → 10 forwarded, then stall_glb_cnt increments. FCP fccl=12 → 2 more pass.
- **Stale FCP.** FCP(vc3, fccr=8) then FCP(vc3, fccr=6) → fccr[3] stays 8.
- **Backpressure.** m_tready toggled randomly → no cell lost or duplicated, data stable while stalled, order preserved.
- **Wrap.** Force tx_cnt[7]=0xFFFFFFF8, fccr=0xFFFFFFF8; send 16 cells → all 16 pass and the 17th blocks.

Source files
------------

// File: rtl/fcp_pkg.sv
// Shared types, default sizes and modular credit comparisons for the FCP credit gate.
// Every credit comparison is a wrapped difference, so it stays correct across counter roll-over.
package fcp_pkg;

  localparam int FCP_QUEUE_INDEX_WIDTH = 13;
  localparam int FCP_STAT_WIDTH        = 32;
  localparam int FCP_VC_FIELD_LSB      = 16;

  typedef logic [FCP_STAT_WIDTH-1:0]        stat_t;
  typedef logic [FCP_QUEUE_INDEX_WIDTH-1:0] vc_t;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  // Outstanding count (a - b), taken modulo 2^STAT_WIDTH, is below lim.
  function automatic logic credit_lt(stat_t a, stat_t b, stat_t lim);
    stat_t diff;
    diff = a - b;
    return diff < lim;
  endfunction

  // a is strictly ahead of b in modular sequence space.
  function automatic logic newer(stat_t a, stat_t b);
    stat_t diff;
    diff = a - b;
    return $signed(diff) > 0;
  endfunction

endpackage

// File: rtl/fcp_credit_gate_if.sv
// Ingress cell stream, egress cell stream, FCP credit stream and status of the credit gate.
// The master modport is the environment side; slave is the gate itself.
interface fcp_credit_gate_if #(
  parameter int DATA_WIDTH        = 64,
  parameter int QUEUE_INDEX_WIDTH = 13,
  parameter int STAT_WIDTH        = 32
);

  logic [DATA_WIDTH-1:0]        s_axis_pkt_tdata;
  logic                         s_axis_pkt_tvalid;
  logic                         s_axis_pkt_tlast;
  logic                         s_axis_pkt_tready;

  logic [DATA_WIDTH-1:0]        m_axis_pkt_tdata;
  logic                         m_axis_pkt_tvalid;
  logic                         m_axis_pkt_tlast;
  logic                         m_axis_pkt_tready;

  logic                         fcp_valid;
  logic [QUEUE_INDEX_WIDTH-1:0] fcp_vc;
  logic [STAT_WIDTH-1:0]        fcp_fccr;
  logic [STAT_WIDTH-1:0]        fcp_fccl;

  logic                         init_done;
  logic [STAT_WIDTH-1:0]        stall_vc_cnt;
  logic [STAT_WIDTH-1:0]        stall_glb_cnt;

  modport master (
    output s_axis_pkt_tdata, s_axis_pkt_tvalid, s_axis_pkt_tlast,
    input  s_axis_pkt_tready,
    input  m_axis_pkt_tdata, m_axis_pkt_tvalid, m_axis_pkt_tlast,
    output m_axis_pkt_tready,
    output fcp_valid, fcp_vc, fcp_fccr, fcp_fccl,
    input  init_done, stall_vc_cnt, stall_glb_cnt
  );

  modport slave (
    input  s_axis_pkt_tdata, s_axis_pkt_tvalid, s_axis_pkt_tlast,
    output s_axis_pkt_tready,
    output m_axis_pkt_tdata, m_axis_pkt_tvalid, m_axis_pkt_tlast,
    input  m_axis_pkt_tready,
    input  fcp_valid, fcp_vc, fcp_fccr, fcp_fccl,
    output init_done, stall_vc_cnt, stall_glb_cnt
  );

endinterface

// File: rtl/fcp_credit_gate_vc_credit_table.sv
// Per-VC transmitted-cell and drained-cell tables with a post-reset clearing walk,
// stale-filtered FCP writes and an async read that bypasses a same-cycle FCP update.
module vc_credit_table
  import fcp_pkg::*;
#(
  parameter int QUEUE_INDEX_WIDTH = 13,
  parameter int STAT_WIDTH        = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [QUEUE_INDEX_WIDTH-1:0] rd_vc,
  input  logic                         inc,
  input  logic                         fcp_valid,
  input  logic [QUEUE_INDEX_WIDTH-1:0] fcp_vc,
  input  logic [STAT_WIDTH-1:0]        fcp_fccr,
  output logic                         run,
  output logic [STAT_WIDTH-1:0]        tx_cnt,
  output logic [STAT_WIDTH-1:0]        fccr_eff
);

  localparam int DEPTH = 1 << QUEUE_INDEX_WIDTH;

  state_t                       state, state_nxt;
  logic [QUEUE_INDEX_WIDTH:0]   walk_addr;
  logic                         walk_en;
  logic                         fcp_acc;
  logic [STAT_WIDTH-1:0]        tx_ram   [DEPTH];
  logic [STAT_WIDTH-1:0]        fccr_ram [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      walk_addr <= '0;
    end else begin
      state <= state_nxt;
      if (walk_en) walk_addr <= walk_addr + (QUEUE_INDEX_WIDTH+1)'(1);
    end
  end

  // The walk counter's top bit marks the last entry cleared; RUN follows one cycle later.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (walk_addr[QUEUE_INDEX_WIDTH]) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    walk_en = 1'b0;
    run     = 1'b0;
    case (state)
      ST_INIT: walk_en = !walk_addr[QUEUE_INDEX_WIDTH];
      ST_RUN:  run     = 1'b1;
      default: ;
    endcase
  end

  assign fcp_acc = run && fcp_valid && newer(fcp_fccr, fccr_ram[fcp_vc]);

  // NOTE: the RAMs have no reset term; the INIT walk clears them so they map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (walk_en)  tx_ram[walk_addr[QUEUE_INDEX_WIDTH-1:0]] <= '0;
    else if (inc) tx_ram[rd_vc] <= tx_cnt + STAT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (walk_en)      fccr_ram[walk_addr[QUEUE_INDEX_WIDTH-1:0]] <= '0;
    else if (fcp_acc) fccr_ram[fcp_vc] <= fcp_fccr;
  end

  assign tx_cnt   = tx_ram[rd_vc];
  assign fccr_eff = (fcp_acc && fcp_vc == rd_vc) ? fcp_fccr : fccr_ram[rd_vc];

endmodule

// File: rtl/fcp_credit_gate.sv
// Head-of-line credit gate: one holding register in front of one output register, released
// only when the head cell's VC and the global switch buffer both have credit.
module fcp_credit_gate
  import fcp_pkg::*;
#(
  parameter int QUEUE_INDEX_WIDTH = 13,
  parameter int DATA_WIDTH        = 64,
  parameter int STAT_WIDTH        = 32,
  parameter int VC_FIELD_LSB      = FCP_VC_FIELD_LSB,
  parameter int VC_WINDOW         = 16,
  parameter int INIT_FCCL         = 4096
) (
  input  logic            clk,
  input  logic            rst,
  fcp_credit_gate_if.slave bus
);

  logic                         run;
  logic [STAT_WIDTH-1:0]        tx_cnt, fccr_eff;

  logic                         h_valid, h_last;
  logic [QUEUE_INDEX_WIDTH-1:0] h_vc;
  logic [DATA_WIDTH-1:0]        h_data;

  logic                         m_valid, m_last;
  logic [DATA_WIDTH-1:0]        m_data;

  logic [STAT_WIDTH-1:0]        glb_tx, glb_fccl, glb_fccl_eff;
  logic [STAT_WIDTH-1:0]        stall_vc, stall_glb;
  logic                         vc_ok, glb_ok, fire, s_ready;

  vc_credit_table #(
    .QUEUE_INDEX_WIDTH (QUEUE_INDEX_WIDTH),
    .STAT_WIDTH        (STAT_WIDTH)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .rd_vc     (h_vc),
    .inc       (fire),
    .fcp_valid (bus.fcp_valid),
    .fcp_vc    (bus.fcp_vc),
    .fcp_fccr  (bus.fcp_fccr),
    .run       (run),
    .tx_cnt    (tx_cnt),
    .fccr_eff  (fccr_eff)
  );

  // A same-cycle FCP limit applies immediately so a fresh snapshot can release the head cell.
  assign glb_fccl_eff = (run && bus.fcp_valid) ? bus.fcp_fccl : glb_fccl;
  assign vc_ok        = credit_lt(tx_cnt, fccr_eff, STAT_WIDTH'(VC_WINDOW));
  assign glb_ok       = newer(glb_fccl_eff, glb_tx);
  assign fire         = h_valid && vc_ok && glb_ok && (!m_valid || bus.m_axis_pkt_tready);
  assign s_ready      = run && (!h_valid || fire);

  always_ff @(posedge clk) begin
    if (rst) begin
      h_valid <= 1'b0;
      h_last  <= 1'b0;
      h_vc    <= '0;
      h_data  <= '0;
    end else if (bus.s_axis_pkt_tvalid && s_ready) begin
      h_valid <= 1'b1;
      h_last  <= bus.s_axis_pkt_tlast;
      h_vc    <= bus.s_axis_pkt_tdata[VC_FIELD_LSB +: QUEUE_INDEX_WIDTH];
      h_data  <= bus.s_axis_pkt_tdata;
    end else if (fire) begin
      h_valid <= 1'b0;
    end
  end

  // Data only moves on fire, so it holds while valid waits for ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else if (fire) begin
      m_valid <= 1'b1;
      m_last  <= h_last;
      m_data  <= h_data;
    end else if (bus.m_axis_pkt_tready) begin
      m_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      glb_tx   <= '0;
      glb_fccl <= STAT_WIDTH'(INIT_FCCL);
    end else begin
      if (fire)                 glb_tx   <= glb_tx + STAT_WIDTH'(1);
      if (run && bus.fcp_valid) glb_fccl <= bus.fcp_fccl;
    end
  end

  // VC blocking takes precedence; the global counter only sees cells the VC would release.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_vc  <= '0;
      stall_glb <= '0;
    end else if (h_valid && !vc_ok) begin
      if (stall_vc != '1) stall_vc <= stall_vc + STAT_WIDTH'(1);
    end else if (h_valid && !glb_ok) begin
      if (stall_glb != '1) stall_glb <= stall_glb + STAT_WIDTH'(1);
    end
  end

  assign bus.s_axis_pkt_tready = s_ready;
  assign bus.m_axis_pkt_tvalid = m_valid;
  assign bus.m_axis_pkt_tdata  = m_data;
  assign bus.m_axis_pkt_tlast  = m_last;
  assign bus.init_done         = run;
  assign bus.stall_vc_cnt      = stall_vc;
  assign bus.stall_glb_cnt     = stall_glb;

endmodule

// File: tb/tb_fcp_credit_gate.sv
// Directed bench for fcp_credit_gate: table-clear timing, latency, VC window, global credit,
// stale FCP filtering, modular wrap, random egress backpressure and mid-run reset.
module tb_fcp_credit_gate;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fcp_credit_gate_if #(.DATA_WIDTH(64), .QUEUE_INDEX_WIDTH(13), .STAT_WIDTH(32)) bus ();

  fcp_credit_gate u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  int          n_out = 0;
  int          seq   = 0;
  int          base;
  int          cycles;
  logic        rand_ready   = 1'b0;
  logic        last_acc     = 1'b0;
  logic        hold_pending = 1'b0;
  logic [63:0] hold_data    = '0;
  logic [31:0] fccl_cur     = 32'd4096;
  logic [31:0] sv, sg;
  logic [63:0] in_q [$];
  logic [63:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Cell layout: sequence tag in [63:32], VC in [28:16], marker in [15:0].
  task automatic push(input int vc, input int n);
    logic [63:0] c;
    for (int i = 0; i < n; i++) begin
      seq++;
      c = {32'(seq), 3'b000, 13'(vc), 16'hC0DE};
      in_q.push_back(c);
      exp_q.push_back(c);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic tick();
    logic [63:0] e;
    bus.s_axis_pkt_tvalid = (in_q.size() != 0);
    bus.s_axis_pkt_tdata  = (in_q.size() != 0) ? in_q[0] : 64'd0;
    bus.s_axis_pkt_tlast  = 1'b1;
    bus.m_axis_pkt_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    last_acc = bus.s_axis_pkt_tvalid && bus.s_axis_pkt_tready;
    if (hold_pending) begin
      check("hold_valid", 64'(bus.m_axis_pkt_tvalid), 64'd1);
      check("hold_data", bus.m_axis_pkt_tdata, hold_data);
    end
    if (bus.m_axis_pkt_tvalid && bus.m_axis_pkt_tready) begin
      n_out++;
      check("out_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_data", bus.m_axis_pkt_tdata, e);
      end
      check("out_tlast", 64'(bus.m_axis_pkt_tlast), 64'd1);
    end
    hold_pending = bus.m_axis_pkt_tvalid && !bus.m_axis_pkt_tready;
    hold_data    = bus.m_axis_pkt_tdata;
    @(negedge clk);
    if (last_acc) void'(in_q.pop_front());
  endtask

  task automatic send_fcp(input int vc, input logic [31:0] fccr);
    bus.fcp_valid = 1'b1;
    bus.fcp_vc    = 13'(vc);
    bus.fcp_fccr  = fccr;
    bus.fcp_fccl  = fccl_cur;
    tick();
    bus.fcp_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_axis_pkt_tdata  = '0;
    bus.s_axis_pkt_tvalid = 1'b0;
    bus.s_axis_pkt_tlast  = 1'b1;
    bus.m_axis_pkt_tready = 1'b1;
    bus.fcp_valid         = 1'b0;
    bus.fcp_vc            = '0;
    bus.fcp_fccr          = '0;
    bus.fcp_fccl          = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_tready", 64'(bus.s_axis_pkt_tready), 64'd0);
    check("rst_m_valid", 64'(bus.m_axis_pkt_tvalid), 64'd0);
    check("rst_m_data", bus.m_axis_pkt_tdata, 64'd0);
    check("rst_m_last", 64'(bus.m_axis_pkt_tlast), 64'd0);
    check("rst_init_done", 64'(bus.init_done), 64'd0);
    check("rst_stall_vc", 64'(bus.stall_vc_cnt), 64'd0);
    check("rst_stall_glb", 64'(bus.stall_glb_cnt), 64'd0);

    // Table clear: init_done appears 8193 edges after release
    rst    = 1'b0;
    cycles = 0;
    while (!bus.init_done && cycles < 10000) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check("init_cycles", 64'(cycles), 64'd8193);
    @(negedge clk);
    check("run_tready", 64'(bus.s_axis_pkt_tready), 64'd1);

    // Latency: accepted at edge k, visible after edge k+1
    push(1, 1);
    tick();
    check("lat_accept", 64'(last_acc), 64'd1);
    check("lat_edge_k", 64'(bus.m_axis_pkt_tvalid), 64'd0);
    tick();
    check("lat_edge_k1", 64'(bus.m_axis_pkt_tvalid), 64'd1);
    tick();

    // VC window: 16 outstanding on VC 5, then blocked until FCP returns 4
    base = n_out;
    push(5, 20);
    repeat (40) tick();
    check("vc_win_fwd", 64'(n_out - base), 64'd16);
    check("vc_win_tready", 64'(bus.s_axis_pkt_tready), 64'd0);
    sv = bus.stall_vc_cnt;
    repeat (5) tick();
    check("vc_stall_inc", 64'(bus.stall_vc_cnt - sv), 64'd5);
    check("vc_glb_stall_zero", 64'(bus.stall_glb_cnt), 64'd0);
    send_fcp(5, 32'd4);
    check("vc_bypass", 64'(last_acc), 64'd1);
    repeat (10) tick();
    check("vc_fcp_fwd", 64'(n_out - base), 64'd20);

    // Global credit: 21 sent so far, limit 31 lets 10 of 12 through
    base     = n_out;
    fccl_cur = 32'd31;
    send_fcp(100, 32'd0);
    for (int v = 10; v < 22; v++) push(v, 1);
    repeat (30) tick();
    check("glb_fwd", 64'(n_out - base), 64'd10);
    sg = bus.stall_glb_cnt;
    sv = bus.stall_vc_cnt;
    repeat (5) tick();
    check("glb_stall_inc", 64'(bus.stall_glb_cnt - sg), 64'd5);
    check("glb_vc_stall_flat", 64'(bus.stall_vc_cnt), 64'(sv));
    fccl_cur = 32'd33;
    send_fcp(100, 32'd0);
    repeat (10) tick();
    check("glb_fcp_fwd", 64'(n_out - base), 64'd12);

    // Global check is signed: a limit 2^31 ahead reads as behind
    base = n_out;
    push(30, 1);
    fccl_cur = 32'd33 + 32'h8000_0000;
    send_fcp(100, 32'd0);
    repeat (5) tick();
    check("glb_sign_block", 64'(n_out - base), 64'd0);
    fccl_cur = 32'd33 + 32'h7FFF_FFFF;
    send_fcp(100, 32'd0);
    repeat (5) tick();
    check("glb_sign_pass", 64'(n_out - base), 64'd1);
    fccl_cur = 32'h4000_0000;

    // Stale FCP on VC 3: 8 then 6 leaves fccr at 8, so 4 more cells fit in the window
    base = n_out;
    push(3, 20);
    repeat (40) tick();
    check("stale_pre", 64'(n_out - base), 64'd16);
    send_fcp(3, 32'd8);
    repeat (10) tick();
    check("stale_first", 64'(n_out - base), 64'd20);
    send_fcp(3, 32'd6);
    push(3, 4);
    repeat (12) tick();
    check("stale_drop", 64'(n_out - base), 64'd24);
    push(3, 1);
    repeat (5) tick();
    check("win_edge_block", 64'(n_out - base), 64'd24);
    send_fcp(3, 32'd9);
    repeat (5) tick();
    check("win_edge_pass", 64'(n_out - base), 64'd25);

    // Wrap on VC 7: fccr steps past 2^31 and past 2^32 while tx_cnt sits near zero
    base = n_out;
    send_fcp(7, 32'h7FFF_FFFF);
    send_fcp(7, 32'hFFFF_FFF8);
    push(7, 10);
    repeat (25) tick();
    check("wrap_fwd", 64'(n_out - base), 64'd8);
    send_fcp(7, 32'd2);
    repeat (8) tick();
    check("wrap_fcp_fwd", 64'(n_out - base), 64'd10);

    // Random egress backpressure: count, order and hold-while-stalled
    base       = n_out;
    rand_ready = 1'b1;
    for (int v = 40; v < 70; v++) push(v, 1);
    repeat (200) tick();
    rand_ready = 1'b0;
    repeat (5) tick();
    check("bp_count", 64'(n_out - base), 64'd30);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-operation with a blocked head cell on VC 3
    push(3, 2);
    repeat (3) tick();
    check("pre_rst_stalled", 64'(bus.stall_vc_cnt != 0), 64'd1);
    rst = 1'b1;
    in_q.delete();
    exp_q.delete();
    bus.s_axis_pkt_tvalid = 1'b0;
    @(negedge clk);
    check("mid_rst_tready", 64'(bus.s_axis_pkt_tready), 64'd0);
    check("mid_rst_m_valid", 64'(bus.m_axis_pkt_tvalid), 64'd0);
    check("mid_rst_init_done", 64'(bus.init_done), 64'd0);
    check("mid_rst_stall_vc", 64'(bus.stall_vc_cnt), 64'd0);
    check("mid_rst_stall_glb", 64'(bus.stall_glb_cnt), 64'd0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("reinit_tready", 64'(bus.s_axis_pkt_tready), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
